// File: rtl/p4_router_pkg.sv
// Shared queue-system ingress types for the srTCM policer.
// Exposes the policer colour encoding, the policer config-table selectors,
// default-width bucket types and the pre-colour decode helper.
package p4_router_pkg;

  localparam int unsigned POLICER_COLOR_BITS = 2;

  // Verdict / pre-colour encoding; code 3 is never issued.
  typedef enum logic [POLICER_COLOR_BITS-1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } policer_color_t;

  // cfg_sel codes of the ingress policer tables.
  typedef enum logic [1:0] {
    ING_POLICER_CIR_TABLE  = 2'd0,
    ING_POLICER_CBS_TABLE  = 2'd1,
    ING_POLICER_EBS_TABLE  = 2'd2,
    ING_POLICER_RSVD_TABLE = 2'd3
  } queue_system_table_indecies;

  // Default bucket geometry; modules re-derive widths from their own parameters.
  localparam int unsigned DEF_FRAC_BITS         = 13;
  localparam int unsigned DEF_BUCKET_WHOLE_BITS = 20;
  localparam int unsigned DEF_LEN_WIDTH         = 14;
  localparam int unsigned DEF_BUCKET_W          = DEF_BUCKET_WHOLE_BITS + DEF_FRAC_BITS;
  localparam int unsigned DEF_DECREMENT_W       = DEF_LEN_WIDTH + DEF_FRAC_BITS;

  typedef logic [DEF_BUCKET_W-1:0]    bucket_t;
  typedef logic [DEF_DECREMENT_W-1:0] bucket_decrement_t;

  // Map a raw pre-colour to a verdict colour; the unused code 3 counts as RED.
  function automatic policer_color_t pre_color(input logic [POLICER_COLOR_BITS-1:0] c);
    case (c)
      2'd0:    return GREEN;
      2'd1:    return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/qsys_srtcm_bucket.sv
// One queue's srTCM state: CIR increment, CBS/EBS limits and the Tc/Te buckets.
// Applies the granted decrement, then the saturating refill; a config write
// to this queue overrides the result of the same cycle.
// Ports: clk/sreset; cfg_we_i/cfg_sel_i/cfg_data_i table write;
//        dec_tc_i/dec_te_i/dec_amt_i decrement grant; tc_o/te_o current buckets.
module qsys_srtcm_bucket
  import p4_router_pkg::*;
#(
  parameter int unsigned INC_W       = 16,
  parameter int unsigned BKT_WHOLE_W = 20,
  parameter int unsigned FRAC_BITS   = 13,
  parameter int unsigned THREE_COLOR = 1
) (
  input  logic                             clk,
  input  logic                             sreset,
  input  logic                             cfg_we_i,
  input  queue_system_table_indecies       cfg_sel_i,
  input  logic [31:0]                      cfg_data_i,
  input  logic                             dec_tc_i,
  input  logic                             dec_te_i,
  input  logic [BKT_WHOLE_W+FRAC_BITS-1:0] dec_amt_i,
  output logic [BKT_WHOLE_W+FRAC_BITS-1:0] tc_o,
  output logic [BKT_WHOLE_W+FRAC_BITS-1:0] te_o
);

  localparam int unsigned BKT_W = BKT_WHOLE_W + FRAC_BITS;
  localparam int unsigned SUM_W = BKT_W + 1;

  logic [INC_W-1:0]       inc_q, inc_d;
  logic [BKT_WHOLE_W-1:0] cbs_q, cbs_d, ebs_q, ebs_d;
  logic [BKT_W-1:0]       tc_q, tc_d, te_q, te_d;
  logic [BKT_W-1:0]       cap_c_c, cap_e_c, tc_post_c, te_post_c;
  logic [SUM_W-1:0]       tc_sum_c, te_sum_c;
  logic                   cfg_data_unused_c;

  // Only the low field bits of a config word are meaningful.
  assign cfg_data_unused_c = ^cfg_data_i;

  // Decrement, then refill Tc toward CBS; once Tc is full the increment spills into Te.
  always_comb begin
    inc_d     = inc_q;
    cbs_d     = cbs_q;
    ebs_d     = ebs_q;
    cap_c_c   = {cbs_q, {FRAC_BITS{1'b0}}};
    cap_e_c   = {ebs_q, {FRAC_BITS{1'b0}}};
    tc_post_c = dec_tc_i ? (tc_q - dec_amt_i) : tc_q;
    te_post_c = dec_te_i ? (te_q - dec_amt_i) : te_q;
    tc_sum_c  = SUM_W'(tc_post_c) + SUM_W'(inc_q);
    te_sum_c  = SUM_W'(te_post_c) + SUM_W'(inc_q);
    tc_d      = tc_post_c;
    te_d      = te_post_c;

    // Overflow past CBS in the cycle Tc fills is discarded, not carried to Te.
    if (tc_post_c < cap_c_c) begin
      tc_d = (tc_sum_c > SUM_W'(cap_c_c)) ? cap_c_c : tc_sum_c[BKT_W-1:0];
    end else if (THREE_COLOR != 0) begin
      te_d = (te_sum_c > SUM_W'(cap_e_c)) ? cap_e_c : te_sum_c[BKT_W-1:0];
    end

    if (cfg_we_i) begin
      case (cfg_sel_i)
        ING_POLICER_CIR_TABLE: inc_d = cfg_data_i[INC_W-1:0];
        ING_POLICER_CBS_TABLE: begin
          cbs_d = cfg_data_i[BKT_WHOLE_W-1:0];
          tc_d  = {cfg_data_i[BKT_WHOLE_W-1:0], {FRAC_BITS{1'b0}}};
        end
        ING_POLICER_EBS_TABLE: begin
          ebs_d = cfg_data_i[BKT_WHOLE_W-1:0];
          te_d  = {cfg_data_i[BKT_WHOLE_W-1:0], {FRAC_BITS{1'b0}}};
        end
        default: ;
      endcase
    end

    if (THREE_COLOR == 0) begin
      te_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      inc_q <= '0;
      cbs_q <= '0;
      ebs_q <= '0;
      tc_q  <= '0;
      te_q  <= '0;
    end else begin
      inc_q <= inc_d;
      cbs_q <= cbs_d;
      ebs_q <= ebs_d;
      tc_q  <= tc_d;
      te_q  <= te_d;
    end
  end

  assign tc_o = tc_q;
  assign te_o = te_q;

endmodule

// File: rtl/qsys_srtcm_policer.sv
// Multi-queue single-rate three-colour marker for the queue-system ingress path.
// Decodes requests and config writes per queue, selects the verdict from the
// addressed queue's buckets and registers the response one cycle after accept.
// Ports: clk/sreset; req_* policing request (ready/valid); resp_* verdict strobe;
//        cfg_* per-queue table write with a one-cycle cfg_ack.
module qsys_srtcm_policer
  import p4_router_pkg::*;
#(
  parameter int unsigned NUM_QUEUES        = 16,
  parameter int unsigned INC_WHOLE_BITS    = 3,
  parameter int unsigned FRAC_BITS         = 13,
  parameter int unsigned BUCKET_WHOLE_BITS = 20,
  parameter int unsigned LEN_WIDTH         = 14,
  parameter int unsigned THREE_COLOR       = 1,
  parameter int unsigned COLOR_AWARE       = 0,
  localparam int unsigned QW               = $clog2(NUM_QUEUES)
) (
  input  logic                          clk,
  input  logic                          sreset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [QW-1:0]                 req_queue,
  input  logic [LEN_WIDTH-1:0]          req_len,
  input  logic [POLICER_COLOR_BITS-1:0] req_color,
  output logic                          resp_valid,
  output logic [QW-1:0]                 resp_queue,
  output logic [POLICER_COLOR_BITS-1:0] resp_color,
  output logic                          resp_drop,
  input  logic                          cfg_wr,
  input  logic [1:0]                    cfg_sel,
  input  logic [QW-1:0]                 cfg_addr,
  input  logic [31:0]                   cfg_data,
  output logic                          cfg_ack
);

  localparam int unsigned INC_W = INC_WHOLE_BITS + FRAC_BITS;
  localparam int unsigned BKT_W = BUCKET_WHOLE_BITS + FRAC_BITS;

  logic [BKT_W-1:0] tc_all [NUM_QUEUES];
  logic [BKT_W-1:0] te_all [NUM_QUEUES];

  logic           ready_q, resp_valid_q, resp_drop_q, cfg_ack_q;
  logic [QW-1:0]  resp_queue_q;
  policer_color_t resp_color_q;

  logic             accept_c, in_range_c, dec_tc_c, dec_te_c;
  logic [QW-1:0]    sel_queue_c;
  logic [BKT_W-1:0] amt_c, tc_sel_c, te_sel_c;
  policer_color_t   pre_c, verdict_c;

  // Verdict from the pre-edge bucket values of the addressed queue.
  always_comb begin
    accept_c    = req_valid & ready_q;
    in_range_c  = 32'(req_queue) < NUM_QUEUES;
    sel_queue_c = in_range_c ? req_queue : '0;
    tc_sel_c    = tc_all[sel_queue_c];
    te_sel_c    = te_all[sel_queue_c];
    amt_c       = BKT_W'(req_len) << FRAC_BITS;
    pre_c       = (COLOR_AWARE != 0) ? pre_color(req_color) : GREEN;
    verdict_c   = RED;
    dec_tc_c    = 1'b0;
    dec_te_c    = 1'b0;

    if (!in_range_c) begin
      verdict_c = RED;
    end else if (req_len == '0) begin
      verdict_c = GREEN;
    end else if ((pre_c == GREEN) && (tc_sel_c >= amt_c)) begin
      verdict_c = GREEN;
      dec_tc_c  = 1'b1;
    end else if ((pre_c != RED) && (THREE_COLOR != 0) && (te_sel_c >= amt_c)) begin
      verdict_c = YELLOW;
      dec_te_c  = 1'b1;
    end
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
    logic hit_c, wr_c;

    assign hit_c = accept_c && (req_queue == QW'(q));
    assign wr_c  = cfg_wr && (cfg_addr == QW'(q));

    qsys_srtcm_bucket #(
      .INC_W       (INC_W),
      .BKT_WHOLE_W (BUCKET_WHOLE_BITS),
      .FRAC_BITS   (FRAC_BITS),
      .THREE_COLOR (THREE_COLOR)
    ) u_bucket (
      .clk        (clk),
      .sreset     (sreset),
      .cfg_we_i   (wr_c),
      .cfg_sel_i  (queue_system_table_indecies'(cfg_sel)),
      .cfg_data_i (cfg_data),
      .dec_tc_i   (hit_c & dec_tc_c),
      .dec_te_i   (hit_c & dec_te_c),
      .dec_amt_i  (amt_c),
      .tc_o       (tc_all[q]),
      .te_o       (te_all[q])
    );
  end

  // Response and handshake registers; reset squashes any in-flight verdict.
  always_ff @(posedge clk) begin
    if (sreset) begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_queue_q <= '0;
      resp_color_q <= RED;
      resp_drop_q  <= 1'b0;
      cfg_ack_q    <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      resp_valid_q <= accept_c;
      cfg_ack_q    <= cfg_wr;
      if (accept_c) begin
        resp_queue_q <= req_queue;
        resp_color_q <= verdict_c;
        resp_drop_q  <= (verdict_c == RED);
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_queue = resp_queue_q;
  assign resp_color = resp_color_q;
  assign resp_drop  = resp_drop_q;
  assign cfg_ack    = cfg_ack_q;

endmodule

// File: tb/tb_qsys_srtcm_policer.sv
// Self-checking bench for qsys_srtcm_policer (6 queues, colour-aware, three-colour).
// A cycle-level reference model of the token-bucket rules runs alongside the DUT.
module tb_qsys_srtcm_policer;
  import p4_router_pkg::*;

  localparam int NQ = 6;
  localparam int QW = 3;
  localparam longint ONE = 8192;

  logic        clk = 1'b0;
  logic        sreset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_queue = '0;
  logic [13:0] req_len = '0;
  logic [1:0]  req_color = '0;
  logic        resp_valid;
  logic [2:0]  resp_queue;
  logic [1:0]  resp_color;
  logic        resp_drop;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ack;

  always #5 clk = ~clk;

  qsys_srtcm_policer #(
    .NUM_QUEUES  (NQ),
    .THREE_COLOR (1),
    .COLOR_AWARE (1)
  ) dut (
    .clk        (clk),
    .sreset     (sreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_queue  (req_queue),
    .req_len    (req_len),
    .req_color  (req_color),
    .resp_valid (resp_valid),
    .resp_queue (resp_queue),
    .resp_color (resp_color),
    .resp_drop  (resp_drop),
    .cfg_wr     (cfg_wr),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ack    (cfg_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, buckets in 1/8192-byte units.
  longint m_inc [NQ];
  longint m_cbs [NQ];
  longint m_ebs [NQ];
  longint m_tc  [NQ];
  longint m_te  [NQ];
  bit     m_rdy = 1'b0;

  // Expected outputs after the most recent step.
  bit e_valid, e_ack;
  int e_color, e_queue;

  // One clock: drive inputs, predict the verdict, advance the model, sample after the edge.
  task automatic step(input bit rst, input bit v, input int q, input int len, input int col,
                      input bit wr, input int sel, input int addr, input logic [31:0] data);
    int pre;
    longint b, tc, te, cc, ce;
    bit dtc, dte;
    @(negedge clk);
    sreset = rst; req_valid = v; req_queue = 3'(q); req_len = 14'(len); req_color = 2'(col);
    cfg_wr = wr; cfg_sel = 2'(sel); cfg_addr = 3'(addr); cfg_data = data;
    b = longint'(len) * ONE;
    dtc = 0; dte = 0;
    e_valid = v && m_rdy && !rst;
    e_queue = q;
    e_color = RED;
    e_ack   = wr && !rst;
    if (e_valid) begin
      pre = (col == 3) ? int'(RED) : col;
      if (q >= NQ)                          e_color = RED;
      else if (len == 0)                    e_color = GREEN;
      else if (pre == GREEN && m_tc[q] >= b) begin e_color = GREEN;  dtc = 1; end
      else if (pre != RED && m_te[q] >= b)   begin e_color = YELLOW; dte = 1; end
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NQ; i++) begin
        m_inc[i] = 0; m_cbs[i] = 0; m_ebs[i] = 0; m_tc[i] = 0; m_te[i] = 0;
      end
      m_rdy = 0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        tc = m_tc[i] - ((dtc && q == i) ? b : 0);
        te = m_te[i] - ((dte && q == i) ? b : 0);
        cc = m_cbs[i] * ONE;
        ce = m_ebs[i] * ONE;
        if (tc < cc) tc = (tc + m_inc[i] > cc) ? cc : tc + m_inc[i];
        else         te = (te + m_inc[i] > ce) ? ce : te + m_inc[i];
        m_tc[i] = tc; m_te[i] = te;
      end
      if (wr && addr < NQ) begin
        case (sel)
          0: m_inc[addr] = longint'(data & 32'h0000_FFFF);
          1: begin m_cbs[addr] = longint'(data & 32'h000F_FFFF); m_tc[addr] = m_cbs[addr] * ONE; end
          2: begin m_ebs[addr] = longint'(data & 32'h000F_FFFF); m_te[addr] = m_ebs[addr] * ONE; end
          default: ;
        endcase
      end
      m_rdy = 1;
    end
    #1;
  endtask

  task automatic cfg(input int q, input int sel, input logic [31:0] data);
    step(0, 0, 0, 0, 0, 1, sel, q, data);
  endtask

  task automatic req(input int q, input int len, input int col);
    step(0, 1, q, len, col, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 10, 0, 1, 1, 1, 32'd50);
      n_cmp++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_color !== 2'(RED) ||
          resp_drop !== 1'b0 || cfg_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state: ready=%b valid=%b color=%0d drop=%b ack=%b want 0/0/2/0/0",
                 req_ready, resp_valid, resp_color, resp_drop, cfg_ack);
      end
    end
    idle();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
    end
    req(0, 1, GREEN);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(RED) || resp_drop !== 1'b1) begin
      n_bad++; $display("FAIL empty_bucket: valid=%b color=%0d drop=%b want 1/2/1", resp_valid, resp_color, resp_drop);
    end
  endtask

  task automatic test_green_red();
    cfg(3, 0, 32'd8192);
    n_cmp++;
    if (cfg_ack !== 1'b1) begin n_bad++; $display("FAIL cfg_ack: got %b want 1", cfg_ack); end
    cfg(3, 1, 32'd1000);
    cfg(3, 2, 32'd0);
    idle();
    n_cmp++;
    if (cfg_ack !== 1'b0) begin n_bad++; $display("FAIL cfg_ack_pulse: got %b want 0", cfg_ack); end
    req(3, 600, GREEN);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(GREEN) || resp_queue !== 3'd3 || resp_drop !== 1'b0) begin
      n_bad++; $display("FAIL first_600: valid=%b color=%0d q=%0d drop=%b want 1/0/3/0", resp_valid, resp_color, resp_queue, resp_drop);
    end
    req(3, 600, GREEN);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(RED) || resp_drop !== 1'b1) begin
      n_bad++; $display("FAIL b2b_600: valid=%b color=%0d drop=%b want 1/2/1", resp_valid, resp_color, resp_drop);
    end
    // Tc = 400 + 1 + 1 refills by now.
    req(3, 402, GREEN);
    n_cmp++;
    if (resp_color !== 2'(GREEN)) begin n_bad++; $display("FAIL refill_after_dec: color %0d want 0", resp_color); end
  endtask

  task automatic test_yellow();
    cfg(3, 0, 32'd0);
    cfg(3, 1, 32'd100);
    cfg(3, 2, 32'd500);
    req(3, 300, GREEN);
    n_cmp++;
    if (resp_color !== 2'(YELLOW) || resp_drop !== 1'b0) begin
      n_bad++; $display("FAIL yellow_300: color=%0d drop=%b want 1/0", resp_color, resp_drop);
    end
    req(3, 100, GREEN);
    n_cmp++;
    if (resp_color !== 2'(GREEN)) begin n_bad++; $display("FAIL tc_kept_100: color %0d want 0", resp_color); end
    req(3, 200, GREEN);
    n_cmp++;
    if (resp_color !== 2'(YELLOW)) begin n_bad++; $display("FAIL te_left_200: color %0d want 1", resp_color); end
    req(3, 1, GREEN);
    n_cmp++;
    if (resp_color !== 2'(RED)) begin n_bad++; $display("FAIL both_empty: color %0d want 2", resp_color); end
  endtask

  task automatic test_color_aware();
    cfg(3, 1, 32'd1000);
    cfg(3, 2, 32'd500);
    req(3, 64, YELLOW);
    n_cmp++;
    if (resp_color !== 2'(YELLOW)) begin n_bad++; $display("FAIL pre_yellow: color %0d want 1", resp_color); end
    req(3, 1000, GREEN);
    n_cmp++;
    if (resp_color !== 2'(GREEN)) begin n_bad++; $display("FAIL tc_untouched: color %0d want 0", resp_color); end
    req(3, 1, RED);
    n_cmp++;
    if (resp_color !== 2'(RED) || resp_drop !== 1'b1) begin
      n_bad++; $display("FAIL pre_red: color=%0d drop=%b want 2/1", resp_color, resp_drop);
    end
    req(3, 1, 3);
    n_cmp++;
    if (resp_color !== 2'(RED)) begin n_bad++; $display("FAIL pre_code3: color %0d want 2", resp_color); end
    req(3, 1, GREEN);
    n_cmp++;
    if (resp_color !== 2'(YELLOW)) begin n_bad++; $display("FAIL te_436: color %0d want 1", resp_color); end
  endtask

  task automatic test_refill_saturation();
    cfg(4, 0, 32'd0);
    cfg(4, 1, 32'd10);
    cfg(4, 2, 32'd5);
    req(4, 10, GREEN);
    req(4, 5, GREEN);
    n_cmp++;
    if (resp_color !== 2'(YELLOW)) begin n_bad++; $display("FAIL drain_te: color %0d want 1", resp_color); end
    cfg(4, 0, 32'd4096);
    for (int i = 0; i < 19; i++) idle();
    req(4, 10, GREEN);
    n_cmp++;
    if (resp_color !== 2'(RED)) begin n_bad++; $display("FAIL tc_9p5: color %0d want 2", resp_color); end
    for (int i = 0; i < 4; i++) idle();
    req(4, 2, YELLOW);
    n_cmp++;
    if (resp_color !== 2'(YELLOW)) begin n_bad++; $display("FAIL te_accum_2: color %0d want 1", resp_color); end
    req(4, 1, YELLOW);
    n_cmp++;
    if (resp_color !== 2'(RED)) begin n_bad++; $display("FAIL te_0p5: color %0d want 2", resp_color); end
  endtask

  task automatic test_cfg_collision();
    cfg(5, 0, 32'd0);
    cfg(5, 1, 32'd0);
    cfg(5, 2, 32'd0);
    step(0, 1, 5, 1500, GREEN, 1, 1, 5, 32'd2000);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(RED) || cfg_ack !== 1'b1) begin
      n_bad++; $display("FAIL collide: valid=%b color=%0d ack=%b want 1/2/1", resp_valid, resp_color, cfg_ack);
    end
    req(5, 2000, GREEN);
    n_cmp++;
    if (resp_color !== 2'(GREEN) || cfg_ack !== 1'b0) begin
      n_bad++; $display("FAIL write_wins: color=%0d ack=%b want 0/0", resp_color, cfg_ack);
    end
    cfg(5, 1, 32'hFFF0_0032);
    req(5, 51, GREEN);
    n_cmp++;
    if (resp_color !== 2'(RED)) begin n_bad++; $display("FAIL upper_bits_51: color %0d want 2", resp_color); end
    req(5, 50, GREEN);
    n_cmp++;
    if (resp_color !== 2'(GREEN)) begin n_bad++; $display("FAIL upper_bits_50: color %0d want 0", resp_color); end
    cfg(5, 3, 32'd100);
    n_cmp++;
    if (cfg_ack !== 1'b1) begin n_bad++; $display("FAIL rsvd_ack: got %b want 1", cfg_ack); end
    req(5, 1, GREEN);
    n_cmp++;
    if (resp_color !== 2'(RED)) begin n_bad++; $display("FAIL rsvd_ignored: color %0d want 2", resp_color); end
  endtask

  task automatic test_edges();
    req(5, 0, RED);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(GREEN) || resp_drop !== 1'b0) begin
      n_bad++; $display("FAIL zero_len: valid=%b color=%0d drop=%b want 1/0/0", resp_valid, resp_color, resp_drop);
    end
    req(7, 10, GREEN);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(RED) || resp_queue !== 3'd7 || resp_drop !== 1'b1) begin
      n_bad++; $display("FAIL out_of_range: valid=%b color=%0d q=%0d drop=%b want 1/2/7/1", resp_valid, resp_color, resp_queue, resp_drop);
    end
  endtask

  task automatic test_back_to_back_random();
    int v, q, len, col, wr, sel, addr;
    logic [31:0] data;
    for (int i = 0; i < NQ; i++) begin
      cfg(i, 0, $urandom_range(0, 65535));
      cfg(i, 1, $urandom_range(0, 3000));
      cfg(i, 2, $urandom_range(0, 3000));
    end
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      q    = $urandom_range(0, NQ);
      len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 1500);
      col  = $urandom_range(0, 3);
      wr   = ($urandom_range(0, 9) == 0);
      sel  = $urandom_range(0, 3);
      addr = $urandom_range(0, NQ);
      data = (sel == 0) ? $urandom() : (($urandom() & 32'hFFF0_0000) | 32'($urandom_range(0, 3000)));
      step(0, v[0], q, len, col, wr[0], sel, addr, data);
      n_cmp++;
      if (resp_valid !== e_valid || cfg_ack !== e_ack) begin
        n_bad++; $display("FAIL rnd_strobe[%0d]: valid=%b ack=%b want %b/%b", n, resp_valid, cfg_ack, e_valid, e_ack);
      end
      if (e_valid) begin
        n_cmp++;
        if (resp_color !== 2'(e_color) || resp_queue !== 3'(e_queue) || resp_drop !== (e_color == RED)) begin
          n_bad++;
          $display("FAIL rnd_verdict[%0d]: color=%0d q=%0d drop=%b want %0d/%0d/%b",
                   n, resp_color, resp_queue, resp_drop, e_color, e_queue, (e_color == RED));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    cfg(3, 1, 32'd1000);
    req(3, 10, GREEN);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(GREEN)) begin
      n_bad++; $display("FAIL pre_reset_accept: valid=%b color=%0d want 1/0", resp_valid, resp_color);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 3, 10, GREEN, 0, 0, 0, 0);
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL squash: valid=%b ready=%b want 0/0", resp_valid, req_ready);
      end
    end
    idle();
    req(3, 1, GREEN);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_color !== 2'(RED)) begin
      n_bad++; $display("FAIL buckets_cleared: valid=%b color=%0d want 1/2", resp_valid, resp_color);
    end
  endtask

  initial begin
    for (int i = 0; i < NQ; i++) begin
      m_inc[i] = 0; m_cbs[i] = 0; m_ebs[i] = 0; m_tc[i] = 0; m_te[i] = 0;
    end
    test_reset();
    test_green_red();
    test_yellow();
    test_color_aware();
    test_refill_saturation();
    test_cfg_collision();
    test_edges();
    test_back_to_back_random();
    test_reset_midstream();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
